// File: rtl/flag_mon_pkg.sv
// Shared definitions for the flag-monitor block family: window FSM states and
// default sizing reused by the window generator and the monitor bench.
package flag_mon_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_OPEN  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DELAY = ST_DELAY,
        OPEN  = ST_OPEN,
        GAP   = ST_GAP
    } win_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop-chain synchroniser for a single asynchronous bit; every stage
// clears to 0 on reset so the output is known before the first clock.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_reg <= 1'b0;
                    end else begin
                        q_reg <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_reg <= 1'b0;
                    end else begin
                        q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/flag_window_gen.sv
// Window strobe generator feeding the flag monitor: delayed, single-shot or
// repeating windows with a done pulse, a saturating window count and a flag synchroniser.
module flag_window_gen
    import flag_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] win_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic             flag_async,
    output logic             window,
    output logic             flag_in,
    output logic             win_done,
    output logic             busy,
    output logic [CNT_W-1:0] win_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Phase lengths of 0 behave as 1, so the loaded down-count is max(v,1)-1.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    win_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stop_pend_reg, stop_pend_next;
    logic             cont_reg;
    logic [CNT_W-1:0] win_len_reg;
    logic [CNT_W-1:0] gap_len_reg;
    logic             window_reg;
    logic             win_done_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] win_cnt_reg;
    logic             win_close;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        stop_pend_next = stop_pend_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (offset == '0) begin
                        state_next = OPEN;
                        cnt_next   = len_m1(win_len);
                    end else begin
                        state_next = DELAY;
                        cnt_next   = offset - ONE;
                    end
                end
            end
            DELAY: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = OPEN;
                    cnt_next   = len_m1(win_len_reg);
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            OPEN: begin
                // A window always runs to its full length; stop only prevents the next one.
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    if (cont_reg && !stop_pend_reg && !stop) begin
                        state_next = GAP;
                        cnt_next   = len_m1(gap_len_reg);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            GAP: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = OPEN;
                    cnt_next   = len_m1(win_len_reg);
                end else begin
                    cnt_next = cnt_reg - ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == IDLE) begin
            stop_pend_next = 1'b0;
            cnt_next       = '0;
        end
    end

    assign win_close = (state_reg == OPEN) && (state_next != OPEN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            stop_pend_reg <= 1'b0;
            window_reg    <= 1'b0;
            win_done_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            win_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stop_pend_reg <= stop_pend_next;
            // Registered from next-state so the strobe is a clean flop output.
            window_reg    <= (state_next == OPEN);
            busy_reg      <= (state_next != IDLE);
            win_done_reg  <= win_close;
            if (win_close && (win_cnt_reg != '1)) begin
                win_cnt_reg <= win_cnt_reg + ONE;
            end
        end
    end

    // The start offset is consumed directly by the DELAY down-count, so only
    // the parameters needed after the first phase are shadowed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cont_reg    <= 1'b0;
            win_len_reg <= '0;
            gap_len_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            cont_reg    <= continuous;
            win_len_reg <= win_len;
            gap_len_reg <= gap_len;
        end
    end

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_flag_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (flag_async),
        .q       (flag_in)
    );

    assign window   = window_reg;
    assign win_done = win_done_reg;
    assign busy     = busy_reg;
    assign win_cnt  = win_cnt_reg;

endmodule
